// File: rtl/bus_master_if.sv
// bus_master_if: single-outstanding bridge from the pipeline load/store
// port onto the shared tri-state device bus (arbitrated, 1-cycle write, RD_LAT+1-cycle read).
module bus_master_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1,
  parameter int GNT_TO = 15
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_bus_req,
  input  logic              i_bus_gnt,
  output logic              o_bus_en,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic              o_bus_ctrl,
  inout  wire  [DATA_W-1:0] io_bus_data
);

  localparam logic       CTRL_WRITE = 1'b1;
  localparam logic       CTRL_READ  = 1'b0;
  localparam logic [7:0] GNT_MAX    = 8'(GNT_TO);
  localparam logic [2:0] LAT_MAX    = 3'(RD_LAT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_WR,
    S_RD,
    S_RSP
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic [7:0]          r_gcnt;
  logic [2:0]          r_lcnt;
  logic                w_gnt_to;
  logic                w_lat_done;

  assign w_gnt_to   = (r_gcnt == GNT_MAX);
  assign w_lat_done = (r_lcnt == LAT_MAX);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_gcnt  <= '0;
      r_lcnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_we    <= i_req_we;
            r_addr  <= i_req_addr;
            r_wdata <= i_req_wdata;
            r_err   <= 1'b0;
            r_gcnt  <= '0;
            if (i_req_we) r_rdata <= '0;
          end
        end
        S_ARB: begin
          r_lcnt <= '0;
          if (!i_bus_gnt) begin
            if (w_gnt_to) begin
              r_err   <= 1'b1;
              r_rdata <= '0;
            end else begin
              r_gcnt <= r_gcnt + 8'd1;
            end
          end
        end
        S_RD: begin
          if (w_lat_done) r_rdata <= io_bus_data;
          else            r_lcnt  <= r_lcnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // Grant wins over timeout in the same cycle; outputs are pure state decode
  always_comb begin
    w_next      = r_state;
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    o_bus_req   = 1'b0;
    o_bus_en    = 1'b0;
    o_bus_ctrl  = CTRL_READ;
    case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) w_next = S_ARB;
      end
      S_ARB: begin
        o_bus_req = 1'b1;
        if (i_bus_gnt)     w_next = r_we ? S_WR : S_RD;
        else if (w_gnt_to) w_next = S_RSP;
      end
      S_WR: begin
        o_bus_req  = 1'b1;
        o_bus_en   = 1'b1;
        o_bus_ctrl = CTRL_WRITE;
        w_next     = S_RSP;
      end
      S_RD: begin
        o_bus_req = 1'b1;
        o_bus_en  = 1'b1;
        if (w_lat_done) w_next = S_RSP;
      end
      S_RSP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign o_rsp_rdata = r_rdata;
  assign o_rsp_err   = r_err;
  assign o_bus_addr  = r_addr;
  assign io_bus_data = (r_state == S_WR) ? r_wdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_bus_master_if.sv
// tb_bus_master_if: two bridges (RD_LAT=1 and 3) each on its own bus with a RAM model,
// checked against transaction-level timing/data expectations.
module tb_bus_master_if;
  localparam int AW     = 10;
  localparam int DW     = 16;
  localparam int GNT_TO = 15;
  localparam int LAT0   = 1;
  localparam int LAT1   = 3;
  localparam logic WR_C = 1'b1;
  localparam logic RD_C = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]         req_valid, req_we, rsp_ready, bus_gnt;
  logic [1:0][AW-1:0] req_addr;
  logic [1:0][DW-1:0] req_wdata;
  logic [1:0]         req_ready, rsp_valid, rsp_err, bus_req, bus_en, bus_ctrl;
  logic [1:0][DW-1:0] rsp_rdata;
  logic [1:0][AW-1:0] bus_addr;
  wire  [DW-1:0]      bd0, bd1;
  logic [1:0][DW-1:0] bd;
  assign bd[0] = bd0;
  assign bd[1] = bd1;

  bus_master_if #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT0), .GNT_TO(GNT_TO)) u_dut0 (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
    .i_req_we(req_we[0]), .i_req_addr(req_addr[0]), .i_req_wdata(req_wdata[0]),
    .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]),
    .o_rsp_rdata(rsp_rdata[0]), .o_rsp_err(rsp_err[0]),
    .o_bus_req(bus_req[0]), .i_bus_gnt(bus_gnt[0]), .o_bus_en(bus_en[0]),
    .o_bus_addr(bus_addr[0]), .o_bus_ctrl(bus_ctrl[0]), .io_bus_data(bd0)
  );

  bus_master_if #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT1), .GNT_TO(GNT_TO)) u_dut1 (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
    .i_req_we(req_we[1]), .i_req_addr(req_addr[1]), .i_req_wdata(req_wdata[1]),
    .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]),
    .o_rsp_rdata(rsp_rdata[1]), .o_rsp_err(rsp_err[1]),
    .o_bus_req(bus_req[1]), .i_bus_gnt(bus_gnt[1]), .o_bus_en(bus_en[1]),
    .o_bus_addr(bus_addr[1]), .o_bus_ctrl(bus_ctrl[1]), .io_bus_data(bd1)
  );

  function automatic int lat_of(int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  // RAM models: valid data only on the RD_LAT-th read cycle, inverted before it
  logic [DW-1:0]      mem  [2][1024];
  logic [DW-1:0]      refm [2][1024];
  int                 rcnt [2];
  logic [1:0]         ram_oe;
  logic [1:0][DW-1:0] ram_q;

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      ram_oe[k] = bus_en[k] && (bus_ctrl[k] == RD_C);
      ram_q[k]  = (rcnt[k] == lat_of(k)) ? mem[k][bus_addr[k]] : ~mem[k][bus_addr[k]];
    end
  end
  assign bd0 = ram_oe[0] ? ram_q[0] : {DW{1'bz}};
  assign bd1 = ram_oe[1] ? ram_q[1] : {DW{1'bz}};

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (bus_en[k] && bus_ctrl[k] == WR_C) mem[k][bus_addr[k]] <= bd[k];
      rcnt[k] <= (bus_en[k] && bus_ctrl[k] == RD_C) ? rcnt[k] + 1 : 0;
    end
  end

  int checks = 0;
  int fails  = 0;

  task automatic chk(string nm, int k, int n, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s inst=%0d cyc=%0d got=%0h exp=%0h", nm, k, n, got, exp);
    end
  endtask

  // One transaction: grant withheld for d ARB cycles, rsp_ready held low rd RSP cycles.
  task automatic txn(int k, bit we, logic [AW-1:0] a, logic [DW-1:0] wd,
                     int d, int rd, bit e_err, logic [DW-1:0] e_rd);
    int  L;
    bit  busy;
    bit  exp_en;
    L = e_err ? GNT_TO + 2 : (we ? d + 3 : d + lat_of(k) + 3);
    chk("ready_idle", k, 0, req_ready[k], 1);
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = a;
    req_wdata[k] = wd;
    bus_gnt[k]   = (d == 0);
    rsp_ready[k] = 1'($urandom_range(0, 1));
    for (int n = 1; n <= L + rd + 1; n++) begin
      @(negedge clk);
      busy   = (n <= L + rd);
      exp_en = !e_err && n >= d + 2 && n < L;
      chk("bus_req",   k, n, bus_req[k],   n < L);
      chk("bus_en",    k, n, bus_en[k],    exp_en);
      chk("bus_ctrl",  k, n, bus_ctrl[k],  (exp_en && we) ? WR_C : RD_C);
      chk("req_ready", k, n, req_ready[k], !busy);
      chk("rsp_valid", k, n, rsp_valid[k], busy && n >= L);
      if (exp_en) chk("bus_addr", k, n, bus_addr[k], a);
      if (exp_en && we) chk("bus_wdata", k, n, bd[k], wd);
      if (busy && n >= L) begin
        chk("rsp_rdata", k, n, rsp_rdata[k], e_rd);
        chk("rsp_err",   k, n, rsp_err[k],   e_err);
      end
      if (busy) begin
        req_valid[k] = 1'($urandom_range(0, 1));
        req_we[k]    = 1'($urandom);
        req_addr[k]  = AW'($urandom);
        req_wdata[k] = DW'($urandom);
        bus_gnt[k]   = (n < L) ? (n - 1 >= d) : 1'($urandom_range(0, 1));
        rsp_ready[k] = (n >= L) ? (n >= L + rd) : 1'($urandom_range(0, 1));
      end else begin
        req_valid[k] = 1'b0;
        bus_gnt[k]   = 1'b0;
        rsp_ready[k] = 1'b1;
      end
    end
    if (we && !e_err) refm[k][a] = wd;
  endtask

  typedef struct {
    bit            we;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    int            d;
    int            rd;
    bit            e_err;
    logic [DW-1:0] e_rd;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    bit            we;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    int            d;
    int            rd;
    bit            e_err;
    logic [DW-1:0] e_rd;

    tbl[0]  = '{1'b1, 10'h012, 16'hBEEF, 0,  0,  1'b0, 16'h0000};
    tbl[1]  = '{1'b0, 10'h012, 16'h0000, 0,  0,  1'b0, 16'hBEEF};
    tbl[2]  = '{1'b1, 10'h3FF, 16'h1234, 5,  0,  1'b0, 16'h0000};
    tbl[3]  = '{1'b0, 10'h3FF, 16'h0000, 5,  0,  1'b0, 16'h1234};
    tbl[4]  = '{1'b0, 10'h012, 16'h0000, 16, 0,  1'b1, 16'h0000};
    tbl[5]  = '{1'b1, 10'h000, 16'hA5A5, 15, 0,  1'b0, 16'h0000};
    tbl[6]  = '{1'b0, 10'h000, 16'h0000, 0,  10, 1'b0, 16'hA5A5};
    tbl[7]  = '{1'b1, 10'h000, 16'h8001, 0,  0,  1'b0, 16'h0000};
    tbl[8]  = '{1'b0, 10'h3FF, 16'h0000, 0,  0,  1'b0, 16'h1234};
    tbl[9]  = '{1'b0, 10'h000, 16'h0000, 0,  0,  1'b0, 16'h8001};
    tbl[10] = '{1'b1, 10'h3FF, 16'hFFFF, 16, 3,  1'b1, 16'h0000};
    tbl[11] = '{1'b0, 10'h3FF, 16'h0000, 0,  0,  1'b0, 16'h1234};

    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 1024; i++) begin
        mem[k][i]  = DW'($urandom) | 16'h0001;
        refm[k][i] = mem[k][i];
      end
    end
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = '1;
    bus_gnt   = '0;

    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_req_ready", k, 0, req_ready[k], 1);
      chk("rst_rsp_valid", k, 0, rsp_valid[k], 0);
      chk("rst_rsp_rdata", k, 0, rsp_rdata[k], 0);
      chk("rst_rsp_err",   k, 0, rsp_err[k],   0);
      chk("rst_bus_req",   k, 0, bus_req[k],   0);
      chk("rst_bus_en",    k, 0, bus_en[k],    0);
      chk("rst_bus_addr",  k, 0, bus_addr[k],  0);
      chk("rst_bus_ctrl",  k, 0, bus_ctrl[k],  RD_C);
    end
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 12; i++)
        txn(k, tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].d, tbl[i].rd, tbl[i].e_err, tbl[i].e_rd);

    // Reset in the middle of a read on the RD_LAT=3 bridge
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b0;
    req_addr[1]  = 10'h155;
    bus_gnt[1]   = 1'b1;
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rd_en", 1, 2, bus_en[1], 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_en",    1, 2, bus_en[1],    0);
    chk("rst_mid_req",   1, 2, bus_req[1],   0);
    chk("rst_mid_ctrl",  1, 2, bus_ctrl[1],  RD_C);
    chk("rst_mid_addr",  1, 2, bus_addr[1],  0);
    chk("rst_mid_valid", 1, 2, rsp_valid[1], 0);
    chk("rst_mid_ready", 1, 2, req_ready[1], 1);
    bus_gnt[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("post_rst_valid", 1, n, rsp_valid[1], 0);
      chk("post_rst_en",    1, n, bus_en[1],    0);
    end
    txn(1, 1'b0, 10'h155, 16'h0, 0, 0, 1'b0, refm[1][10'h155]);
    txn(0, 1'b0, 10'h155, 16'h0, 0, 0, 1'b0, refm[0][10'h155]);

    for (int i = 0; i < 30; i++) begin
      for (int k = 0; k < 2; k++) begin
        we = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
          0:       a = 10'h000;
          1:       a = 10'h3FF;
          default: a = AW'($urandom_range(0, 15));
        endcase
        wd    = DW'($urandom);
        d     = ($urandom_range(0, 7) == 0) ? GNT_TO + 1 : int'($urandom_range(0, GNT_TO));
        rd    = int'($urandom_range(0, 3));
        e_err = (d > GNT_TO);
        e_rd  = (we || e_err) ? 16'h0000 : refm[k][a];
        txn(k, we, a, wd, d, rd, e_err, e_rd);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
